// File: rtl/mic1_exec_ctrl_pkg.sv
// Shared types for the MIC-1 execution controller: controller states and
// the stop-cause code reported on halt_cause.
package mic1_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    USTEP = 2'd2,
    ISTEP = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    USER      = 3'd1,
    BREAK     = 3'd2,
    CPU_HALT  = 3'd3,
    STEP_DONE = 3'd4
  } cause_t;

  // Width of the issued-ce counter shown on the step LEDs.
  localparam int STEP_W = 4;

endpackage

// File: rtl/mic1_exec_ctrl_ce_prescaler.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled and wraps.
// The tick output looks one cycle ahead: it is high when the count will be
// DIV-1 after the coming edge, so a ce registered on that edge lands in the
// same cycle the count sits at DIV-1.
module ce_prescaler #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: clear wins over counting; wrap at DIV-1.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = (clr | en) && (cnt_nxt == LAST);

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/mic1_exec_ctrl.sv
// MIC-1 execution controller. Converts one-cycle command pulses into a gated
// datapath clock enable with free run, micro-step, ISA-step, MPC breakpoint
// and stop on CPU HALT. All outputs come straight from registers.
module mic1_exec_ctrl
  import mic1_ctrl_pkg::*;
#(
  parameter int DIV   = 16,
  parameter int MPC_W = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_ustep,
  input  logic             cmd_istep,
  input  logic             bp_en,
  input  logic [MPC_W-1:0] bp_addr,
  input  logic [MPC_W-1:0] mpc,
  input  logic             instr_done,
  input  logic             cpu_halted,
  output logic             cpu_ce,
  output logic             led_run_status,
  output logic             led_idle,
  output logic [3:0]       led_run_step,
  output logic [2:0]       halt_cause
);

  state_t            state_q;
  state_t            state_nxt;
  cause_t            cause_q;
  cause_t            cause_nxt;
  logic              first_q;
  logic              first_nxt;
  logic              ce_nxt;
  logic              clr;
  logic              en;
  logic              tick;
  logic              run_nxt;
  logic              idle_nxt;
  logic [STEP_W-1:0] step_nxt;

  assign en = (state_q != IDLE);

  ce_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .en     (en),
    .tick   (tick)
  );

  // State register plus every registered output; reset drops cpu_ce at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cause_q        <= NONE;
      first_q        <= 1'b1;
      cpu_ce         <= 1'b0;
      led_run_status <= 1'b0;
      led_idle       <= 1'b1;
      led_run_step   <= '0;
    end else begin
      state_q        <= state_nxt;
      cause_q        <= cause_nxt;
      first_q        <= first_nxt;
      cpu_ce         <= ce_nxt;
      led_run_status <= run_nxt;
      led_idle       <= idle_nxt;
      led_run_step   <= step_nxt;
    end
  end

  // Next state: command acceptance/halt first, then the tick checks in order
  // CPU halt, breakpoint, issue ce (with step completion).
  always_comb begin
    state_nxt = state_q;
    cause_nxt = cause_q;
    first_nxt = first_q;
    ce_nxt    = 1'b0;
    clr       = 1'b0;

    if (state_q == IDLE) begin
      // Halt beats every start command; the remaining order is run > istep > ustep.
      if (!cmd_halt) begin
        if (cmd_run) begin
          state_nxt = RUN;
        end else if (cmd_istep) begin
          state_nxt = ISTEP;
        end else if (cmd_ustep) begin
          state_nxt = USTEP;
        end
        if (state_nxt != IDLE) begin
          clr       = 1'b1;
          first_nxt = 1'b1;
          cause_nxt = NONE;
        end
      end
    end else if (cmd_halt) begin
      // User stop beats a coincident tick, so no ce goes out.
      state_nxt = IDLE;
      cause_nxt = USER;
    end

    if (tick && (state_nxt != IDLE)) begin
      if (cpu_halted) begin
        state_nxt = IDLE;
        cause_nxt = CPU_HALT;
      end else if (bp_en && (mpc == bp_addr) && !first_nxt) begin
        // Skipped on the first tick after a start so a resume can leave the breakpoint.
        state_nxt = IDLE;
        cause_nxt = BREAK;
      end else begin
        ce_nxt    = 1'b1;
        first_nxt = 1'b0;
        if ((state_nxt == USTEP) || ((state_nxt == ISTEP) && instr_done)) begin
          state_nxt = IDLE;
          cause_nxt = STEP_DONE;
        end
      end
    end
  end

  // Output values to be registered alongside the next state.
  always_comb begin
    run_nxt  = (state_nxt == RUN);
    idle_nxt = (state_nxt == IDLE);
    step_nxt = led_run_step + (ce_nxt ? STEP_W'(1) : STEP_W'(0));
  end

  assign halt_cause = cause_q;

endmodule
